// File: rtl/muldiv_sequencer.sv
// Multi-cycle signed 16-bit multiply/divide sequencer for the ID/EX boundary.
// Shift-add multiply and restoring divide on magnitudes, with a final sign-fix step.
module muldiv_sequencer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0]   ZERO_W  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]   ONES_W  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]   ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   MIN_W   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [2*WIDTH-1:0] ONE_DW  = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   CNT_MAX = {CNT_W{1'b1}};

  function automatic logic [WIDTH-1:0] abs_f(input logic [WIDTH-1:0] v);
    if (v[WIDTH-1]) begin
      abs_f = ~v + ONE_W;
    end else begin
      abs_f = v;
    end
  endfunction

  function automatic logic [WIDTH-1:0] neg_w_f(input logic [WIDTH-1:0] v, input logic en);
    neg_w_f = en ? (~v + ONE_W) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_dw_f(input logic [2*WIDTH-1:0] v, input logic en);
    neg_dw_f = en ? (~v + ONE_DW) : v;
  endfunction

  state_t               state_r, next_state_s;
  logic [CNT_W-1:0]     cnt_r;
  logic                 op_r, neg_res_r, neg_rem_r, ovf_pend_r;
  logic [WIDTH-1:0]     opnd_r;
  // acc_r is {hi, multiplier} for multiply and {remainder, quotient} for divide
  logic [2*WIDTH-1:0]   acc_r, acc_next_s;
  logic [WIDTH:0]       mul_sum_s, div_trial_s;
  logic [WIDTH-1:0]     div_sub_s;
  logic                 div_ge_s, dbz_start_s;
  logic [2*WIDTH-1:0]   prod_s;
  logic [WIDTH-1:0]     quo_s, rem_s;

  // One multiply or divide iteration, plus the signed final values
  always_comb begin
    dbz_start_s = start && op && (operand_b == ZERO_W);
    mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + (acc_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    div_trial_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
    div_ge_s    = (div_trial_s >= {1'b0, opnd_r});
    div_sub_s   = div_trial_s[WIDTH-1:0] - opnd_r;
    if (op_r) begin
      if (div_ge_s) begin
        acc_next_s = {div_sub_s, acc_r[WIDTH-2:0], 1'b1};
      end else begin
        acc_next_s = {acc_r[2*WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
    end
    prod_s = neg_dw_f(acc_r, neg_res_r);
    quo_s  = neg_w_f(acc_r[WIDTH-1:0], neg_res_r);
    rem_s  = neg_w_f(acc_r[2*WIDTH-1:WIDTH], neg_rem_r);
  end

  // Next-state and pipeline hold
  always_comb begin
    next_state_s = state_r;
    stall        = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          stall = 1'b1;
          if (dbz_start_s) begin
            next_state_s = DONE;
          end else begin
            next_state_s = CALC;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      CALC: begin
        stall = 1'b1;
        if (cnt_r == {CNT_W{1'b0}}) begin
          next_state_s = SIGN;
        end else begin
          next_state_s = CALC;
        end
      end
      SIGN: begin
        stall        = 1'b1;
        next_state_s = DONE;
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State register with registered busy/done derived from the next state
  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_r <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy    <= (next_state_s == CALC) || (next_state_s == SIGN);
      done    <= (next_state_s == DONE);
    end
  end

  // Operand capture, iteration datapath and result/flag registers
  always_ff @(posedge clk) begin
    if (reset_n) begin
      cnt_r       <= {CNT_W{1'b0}};
      op_r        <= 1'b0;
      neg_res_r   <= 1'b0;
      neg_rem_r   <= 1'b0;
      ovf_pend_r  <= 1'b0;
      opnd_r      <= ZERO_W;
      acc_r       <= {2*WIDTH{1'b0}};
      result_lo   <= ZERO_W;
      result_hi   <= ZERO_W;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            op_r        <= op;
            neg_res_r   <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
            neg_rem_r   <= operand_a[WIDTH-1];
            ovf_pend_r  <= op && (operand_a == MIN_W) && (operand_b == ONES_W);
            cnt_r       <= CNT_MAX;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            if (dbz_start_s) begin
              result_lo   <= ONES_W;
              result_hi   <= operand_a;
              div_by_zero <= 1'b1;
            end else if (op) begin
              opnd_r <= abs_f(operand_b);
              acc_r  <= {ZERO_W, abs_f(operand_a)};
            end else begin
              opnd_r <= abs_f(operand_a);
              acc_r  <= {ZERO_W, abs_f(operand_b)};
            end
          end
        end
        CALC: begin
          acc_r <= acc_next_s;
          cnt_r <= cnt_r - CNT_ONE;
        end
        SIGN: begin
          if (op_r && ovf_pend_r) begin
            result_lo <= MIN_W;
            result_hi <= ZERO_W;
            overflow  <= 1'b1;
          end else if (op_r) begin
            result_lo <= quo_s;
            result_hi <= rem_s;
          end else begin
            result_lo <= prod_s[WIDTH-1:0];
            result_hi <= prod_s[2*WIDTH-1:WIDTH];
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: arithmetic reference model checked
// every cycle, plus directed operations with hand-computed results and latencies.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [15:0] operand_a = 16'h0000;
  logic [15:0] operand_b = 16'h0000;
  logic        stall, busy, done, div_by_zero, overflow;
  logic [15:0] result_lo, result_hi;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  muldiv_sequencer #(.WIDTH(16), .CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .stall(stall), .busy(busy), .done(done),
    .result_lo(result_lo), .result_hi(result_hi),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Reference arithmetic: returns {overflow, div_by_zero, hi, lo}
  function automatic logic [33:0] model_f(input logic o, input logic [15:0] a, input logic [15:0] b);
    int ia, ib, p, q, r;
    logic [15:0] lo, hi;
    logic dz, ov;
    ia = int'($signed(a));
    ib = int'($signed(b));
    dz = 1'b0;
    ov = 1'b0;
    if (!o) begin
      p  = ia * ib;
      lo = p[15:0];
      hi = p[31:16];
    end else if (b == 16'h0000) begin
      lo = 16'hFFFF;
      hi = a;
      dz = 1'b1;
    end else if (a == 16'h8000 && b == 16'hFFFF) begin
      lo = 16'h8000;
      hi = 16'h0000;
      ov = 1'b1;
    end else begin
      q  = ia / ib;
      r  = ia % ib;
      lo = q[15:0];
      hi = r[15:0];
    end
    return {ov, dz, hi, lo};
  endfunction

  // Model: busy for 17 cycles after acceptance, results appear with done
  int          m_busy = 0;
  logic        m_done = 1'b0;
  logic [33:0] m_res = 34'h0;
  logic [33:0] p_res = 34'h0;
  logic [33:0] acc_res;

  always @(posedge clk) begin
    if (reset_n) begin
      m_busy <= 0;
      m_done <= 1'b0;
      m_res  <= 34'h0;
    end else begin
      m_done <= 1'b0;
      if (m_busy > 0) begin
        m_busy <= m_busy - 1;
        if (m_busy == 1) begin
          m_done <= 1'b1;
          m_res  <= p_res;
        end
      end else if (!m_done && start) begin
        acc_res = model_f(op, operand_a, operand_b);
        if (acc_res[32]) begin
          m_done <= 1'b1;
          m_res  <= acc_res;
        end else begin
          m_busy <= 17;
          p_res  <= acc_res;
          m_res  <= {2'b00, m_res[31:0]};
        end
      end
    end
  end

  // Compare DUT against the model every cycle
  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", {31'h0, stall}, {31'h0, (m_busy > 0) || (!m_done && start)});
      chk("busy", {31'h0, busy}, {31'h0, m_busy > 0});
      chk("done", {31'h0, done}, {31'h0, m_done});
      chk("result", {result_hi, result_lo}, m_res[31:0]);
      chk("flags", {30'h0, overflow, div_by_zero}, {30'h0, m_res[33:32]});
    end
  end

  task automatic wait_done(input int t0, output int lat);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        lat = cyc - t0;
        break;
      end
    end
    if (lat < 0) begin
      failures++;
      checks++;
      $display("FAIL timeout waiting for done from cycle %0d", t0);
    end
  endtask

  task automatic run_op(input logic o, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] elo, input logic [15:0] ehi,
                        input logic edz, input logic eov, input int elat);
    int t0, lat;
    @(posedge clk); #1;
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    operand_a = 16'($urandom);
    operand_b = 16'($urandom);
    if (!edz) begin
      @(negedge clk);
      chk("flags_cleared_at_accept", {30'h0, overflow, div_by_zero}, 32'h0);
    end
    wait_done(t0, lat);
    chk("latency", lat, elat);
    chk("lit_lo", {16'h0, result_lo}, {16'h0, elo});
    chk("lit_hi", {16'h0, result_hi}, {16'h0, ehi});
    chk("lit_flags", {30'h0, overflow, div_by_zero}, {30'h0, eov, edz});
  endtask

  initial begin
    int t0, lat;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    chk("reset_outs", {busy, done, div_by_zero, overflow, result_lo, result_hi}, 36'h0);
    reset_n = 1'b0;

    run_op(1'b0, 16'h0003, 16'hFFFE, 16'hFFFA, 16'hFFFF, 1'b0, 1'b0, 18);
    run_op(1'b0, 16'h7FFF, 16'h7FFF, 16'h0001, 16'h3FFF, 1'b0, 1'b0, 18);
    run_op(1'b0, 16'h8000, 16'h8000, 16'h0000, 16'h4000, 1'b0, 1'b0, 18);
    run_op(1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0, 18);
    run_op(1'b1, 16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0, 1'b0, 18);
    run_op(1'b1, 16'h0005, 16'h0000, 16'hFFFF, 16'h0005, 1'b1, 1'b0, 1);
    run_op(1'b0, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0, 18);
    run_op(1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 1'b1, 18);
    run_op(1'b1, 16'h8000, 16'h0003, 16'hD556, 16'hFFFE, 1'b0, 1'b0, 18);

    // Reset mid-CALC, with an ignored start pulse before it
    @(posedge clk); #1;
    start = 1'b1; op = 1'b0; operand_a = 16'h1234; operand_b = 16'h0056;
    t0 = cyc;
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk); #1;
      start   = (k == 5) || (k == 11);
      op      = (k == 5);
      operand_a = (k == 11) ? 16'h0012 : 16'h0005;
      operand_b = (k == 11) ? 16'h0034 : 16'h0000;
      reset_n = (k == 9);
      if (k == 10) begin
        @(negedge clk);
        chk("post_reset_busy_stall_done", {29'h0, busy, stall, done}, 32'h0);
        chk("post_reset_results", {result_hi, result_lo}, 32'h0);
        chk("post_reset_flags", {30'h0, overflow, div_by_zero}, 32'h0);
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(t0, lat);
    chk("restart_latency", lat, 29);
    chk("restart_result", {result_hi, result_lo}, 32'h0000_03A8);

    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
